// File: rtl/pipe_skid_reg.sv
//------------------------------------------------------------------------------
// pipe_skid_reg : elastic 2-entry pipeline register with a registered in_ready.
// Optional perf counters are enabled by defining PIPE_SKID_PERF_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_skid_reg #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Encodings equal the entry count so occupancy is the state itself.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_push;
  logic             w_pop;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) w_next_state = S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      w_next_state = S_FULL;
          else if (!w_push && w_pop) w_next_state = S_EMPTY;
        end
        S_FULL:  if (w_pop) w_next_state = S_ONE;
        default: w_next_state = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (r_state != S_EMPTY);
    in_ready  = (r_state != S_FULL);
    occupancy = r_state;
    out_data  = r_main;
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) r_main <= in_data;
        S_ONE: begin
          if (w_push && w_pop) r_main <= in_data;
          else if (w_push)     r_skid <= in_data;
        end
        S_FULL:  if (w_pop) r_main <= r_skid;
        default: ;
      endcase
    end
  end

`ifdef PIPE_SKID_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating counters; only RST clears them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush && (r_state != S_EMPTY) && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire
